// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - shared button indices, priority order, timing defaults and helpers
package chess_pkg;

    localparam int BTN_NUM = 5;

    localparam int BTN_U = 0;
    localparam int BTN_L = 1;
    localparam int BTN_C = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_REPEAT_DELAY    = 50000000;
    localparam int DEF_REPEAT_PERIOD   = 20000000;

    typedef logic [2:0] btn_idx_t;

    // Highest priority first.
    localparam btn_idx_t [0:BTN_NUM-1] BTN_PRIORITY = '{
        3'(BTN_C), 3'(BTN_U), 3'(BTN_D), 3'(BTN_L), 3'(BTN_R)
    };

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_HELD,
        BTN_REPEAT
    } btn_state_t;

    // One-hot grant of the highest-priority request; the rest are dropped.
    function automatic logic [BTN_NUM-1:0] priority_grant(input logic [BTN_NUM-1:0] req);
        logic [BTN_NUM-1:0] grant;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < BTN_NUM; i++) begin
            if (!found && req[BTN_PRIORITY[i]]) begin
                grant[BTN_PRIORITY[i]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - one channel: synchronizer, debouncer and press/auto-repeat FSM
module button_debounce
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int DB_EFF  = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int RD_EFF  = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
    localparam int RP_EFF  = (REPEAT_PERIOD < 1) ? 1 : REPEAT_PERIOD;
    localparam int RPT_MAX = (RD_EFF > RP_EFF) ? RD_EFF : RP_EFF;
    localparam int DB_W    = $clog2(DB_EFF) + 1;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;

    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_EFF - 1);
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(RD_EFF - 1);
    localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(RP_EFF - 1);

    logic [1:0]       sync_q;
    logic             synced;
    logic             db_level;
    logic [DB_W-1:0]  db_cnt;
    btn_state_t       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pulse_q, pulse_d;

    assign synced    = sync_q[1];
    assign btn_pulse = pulse_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    // The level flips only after DB_EFF consecutive disagreeing cycles.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
        end else if (synced == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt >= DB_LAST) begin
            db_level <= ~db_level;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= BTN_IDLE;
            rpt_cnt_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 1'b0;
        case (state_q)
            BTN_IDLE: begin
                rpt_cnt_d = '0;
                if (db_level) begin
                    state_d = BTN_HELD;
                    pulse_d = 1'b1;
                end
            end
            BTN_HELD: begin
                if (!db_level) begin
                    state_d   = BTN_IDLE;
                    rpt_cnt_d = '0;
                end else if (REPEAT_EN) begin
                    if (rpt_cnt_q >= RD_LAST) begin
                        state_d   = BTN_REPEAT;
                        rpt_cnt_d = '0;
                        pulse_d   = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            BTN_REPEAT: begin
                if (!db_level) begin
                    state_d   = BTN_IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q >= RP_LAST) begin
                    rpt_cnt_d = '0;
                    pulse_d   = 1'b1;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = BTN_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - five debounced push-button channels with a fixed-priority one-hot output
module button_conditioner
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic CLK,
    input  logic RESET,
    input  logic BtnU_raw,
    input  logic BtnL_raw,
    input  logic BtnC_raw,
    input  logic BtnR_raw,
    input  logic BtnD_raw,
    output logic BtnU,
    output logic BtnL,
    output logic BtnC,
    output logic BtnR,
    output logic BtnD
);

    logic [BTN_NUM-1:0] raw_vec;
    logic [BTN_NUM-1:0] pulse_vec;
    logic [BTN_NUM-1:0] out_q;

    always_comb begin
        raw_vec        = '0;
        raw_vec[BTN_U] = BtnU_raw;
        raw_vec[BTN_L] = BtnL_raw;
        raw_vec[BTN_C] = BtnC_raw;
        raw_vec[BTN_R] = BtnR_raw;
        raw_vec[BTN_D] = BtnD_raw;
    end

    // The centre button confirms a selection, so it never auto-repeats.
    for (genvar i = 0; i < BTN_NUM; i++) begin : g_chan
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (i != BTN_C)
        ) u_chan (
            .CLK       (CLK),
            .RESET     (RESET),
            .btn_raw   (raw_vec[i]),
            .btn_pulse (pulse_vec[i])
        );
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_q <= '0;
        end else begin
            out_q <= priority_grant(pulse_vec);
        end
    end

    assign BtnU = out_q[BTN_U];
    assign BtnL = out_q[BTN_L];
    assign BtnC = out_q[BTN_C];
    assign BtnR = out_q[BTN_R];
    assign BtnD = out_q[BTN_D];

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic BtnU_raw = 1'b0, BtnL_raw = 1'b0, BtnC_raw = 1'b0, BtnR_raw = 1'b0, BtnD_raw = 1'b0;
    logic BtnU, BtnL, BtnC, BtnR, BtnD;
    logic [4:0] obs;

    int checks_total  = 0;
    int checks_passed = 0;

    // Observed vector order: {U, L, C, R, D}
    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_U    = 5'b10000;
    localparam logic [4:0] P_L    = 5'b01000;
    localparam logic [4:0] P_C    = 5'b00100;
    localparam logic [4:0] P_R    = 5'b00010;
    localparam logic [4:0] P_D    = 5'b00001;

    always #10 CLK = ~CLK;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BtnU_raw (BtnU_raw),
        .BtnL_raw (BtnL_raw),
        .BtnC_raw (BtnC_raw),
        .BtnR_raw (BtnR_raw),
        .BtnD_raw (BtnD_raw),
        .BtnU     (BtnU),
        .BtnL     (BtnL),
        .BtnC     (BtnC),
        .BtnR     (BtnR),
        .BtnD     (BtnD)
    );

    assign obs = {BtnU, BtnL, BtnC, BtnR, BtnD};

    task automatic set_raw(input logic [4:0] v);
        {BtnU_raw, BtnL_raw, BtnC_raw, BtnR_raw, BtnD_raw} = v;
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        set_raw(P_NONE);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        set_raw(5'b11111);
        #1;
        checks_total++;
        if (obs !== P_NONE) $display("FAIL reset_t0 got=%b exp=%b", obs, P_NONE);
        else checks_passed++;
        for (int c = 0; c < 12; c++) begin
            step();
            checks_total++;
            if (obs !== P_NONE) $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, obs, P_NONE);
            else checks_passed++;
        end
        do_reset();
    endtask

    task automatic test_glitch();
        logic [4:0] exp;
        for (int c = 0; c <= 20; c++) begin
            set_raw((c < 3) ? P_L : P_NONE);
            step();
            exp = P_NONE;
            checks_total++;
            if (obs !== exp) $display("FAIL glitch_l cyc=%0d got=%b exp=%b", c, obs, exp);
            else checks_passed++;
        end
        do_reset();
    endtask

    task automatic test_center_no_repeat();
        logic [4:0] exp;
        for (int c = 0; c <= 60; c++) begin
            set_raw((c < 40) ? P_C : P_NONE);
            step();
            exp = (c == 7) ? P_C : P_NONE;
            checks_total++;
            if (obs !== exp) $display("FAIL center_hold cyc=%0d got=%b exp=%b", c, obs, exp);
            else checks_passed++;
        end
        do_reset();
    endtask

    task automatic test_up_repeat();
        logic [4:0] exp;
        logic       hit;
        for (int c = 0; c <= 60; c++) begin
            set_raw((c < 40) ? P_U : P_NONE);
            step();
            hit = (c == 7) || (c == 17) || (c == 22) || (c == 27) || (c == 32) || (c == 37);
            exp = hit ? P_U : P_NONE;
            // Cycles 41..46 lie between raw release and the debounced fall.
            if (c <= 40 || c >= 47) begin
                checks_total++;
                if (obs !== exp) $display("FAIL up_repeat cyc=%0d got=%b exp=%b", c, obs, exp);
                else checks_passed++;
            end
        end
        do_reset();
    endtask

    task automatic test_priority();
        logic [4:0] exp;
        for (int c = 0; c <= 40; c++) begin
            set_raw((c < 8) ? (P_C | P_R) : P_NONE);
            step();
            exp = (c == 7) ? P_C : P_NONE;
            checks_total++;
            if (obs !== exp) $display("FAIL prio_c_over_r cyc=%0d got=%b exp=%b", c, obs, exp);
            else checks_passed++;
        end
        do_reset();
    endtask

    task automatic test_async_drop();
        logic [4:0] exp;
        for (int c = 0; c <= 7; c++) begin
            set_raw(P_U);
            step();
            exp = (c == 7) ? P_U : P_NONE;
            checks_total++;
            if (obs !== exp) $display("FAIL pre_drop cyc=%0d got=%b exp=%b", c, obs, exp);
            else checks_passed++;
        end
        #3 RESET = 1'b0;
        #1;
        checks_total++;
        if (obs !== P_NONE) $display("FAIL async_drop got=%b exp=%b", obs, P_NONE);
        else checks_passed++;
        do_reset();
    endtask

    task automatic test_reset_mid_debounce();
        logic [4:0] exp;
        for (int c = 0; c <= 5; c++) begin
            set_raw(P_D);
            step();
            checks_total++;
            if (obs !== P_NONE) $display("FAIL pre_reset_d cyc=%0d got=%b exp=%b", c, obs, P_NONE);
            else checks_passed++;
        end
        RESET = 1'b0;
        #1;
        checks_total++;
        if (obs !== P_NONE) $display("FAIL reset_d_async got=%b exp=%b", obs, P_NONE);
        else checks_passed++;
        @(negedge CLK);
        RESET = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            set_raw(P_D);
            step();
            exp = (c == 7) ? P_D : P_NONE;
            checks_total++;
            if (obs !== exp) $display("FAIL post_reset_d cyc=%0d got=%b exp=%b", c, obs, exp);
            else checks_passed++;
        end
        do_reset();
    endtask

    task automatic test_toggle_then_hold();
        logic [4:0] exp;
        // Final rise is sampled at cycle 28 and held from then on.
        for (int c = 0; c <= 43; c++) begin
            set_raw((c >= 30 || ((c / 2) % 2) == 0) ? P_R : P_NONE);
            step();
            exp = (c == 35) ? P_R : P_NONE;
            checks_total++;
            if (obs !== exp) $display("FAIL toggle_r cyc=%0d got=%b exp=%b", c, obs, exp);
            else checks_passed++;
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_center_no_repeat();
        test_up_repeat();
        test_priority();
        test_async_drop();
        test_reset_mid_debounce();
        test_toggle_then_hold();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles needed to accept a level change (10 ms at 100 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 50000000, meaning hold cycles from the accepted press to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 20000000, meaning cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port CLK, input, width 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port RESET, input, width 1, an asynchronous active-low reset.
REQ-006 The block SHALL have ports BtnU_raw, BtnL_raw, BtnC_raw, BtnR_raw and BtnD_raw, input, width 1 each, raw asynchronous push-button levels (1 = pressed).
REQ-007 The block SHALL have ports BtnU, BtnL, BtnC, BtnR and BtnD, output, width 1 each, registered one-cycle press pulses feeding game_logic.

Function
REQ-008 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-009 Each channel SHALL keep a debounced level D, which toggles only after the synchronized input differs from D for DEBOUNCE_CYCLES consecutive cycles.
REQ-010 The stability counter SHALL clear on any cycle where the synchronized input equals D; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no output.
REQ-011 A 0->1 transition of D SHALL produce exactly one output pulse, one cycle wide.
REQ-012 Total latency from the first CLK edge sampling raw=1, with raw held stable, to the pulse SHALL be exactly DEBOUNCE_CYCLES+3 cycles.
REQ-013 A 1->0 transition of D SHALL produce no pulse.
REQ-014 Channels U, L, R and D SHALL auto-repeat; channel C SHALL NOT repeat.
REQ-015 Each channel SHALL run the FSM IDLE -> HELD (on D rise, pulse issued) -> REPEAT (after REPEAT_DELAY cycles in HELD, pulse issued) -> REPEAT (pulse every REPEAT_PERIOD cycles).
REQ-016 Any FSM state SHALL return to IDLE on D fall, with the repeat counter cleared.
REQ-017 Channel C SHALL stay in HELD until D falls.
REQ-018 At most one output SHALL be high in any cycle, with fixed priority C > U > D > L > R.
REQ-019 Lower-priority pulses in a conflicting cycle SHALL be dropped, not queued.
REQ-020 Counters SHALL be sized $clog2 of their largest parameter + 1, SHALL saturate, and SHALL never wrap.
REQ-021 Parameters of 1 SHALL be legal; a value of 0 SHALL be treated as 1.
REQ-022 A raw level held through the deassertion of RESET SHALL be treated as a new press: one pulse DEBOUNCE_CYCLES+3 cycles after deassertion.

Reset
REQ-023 On RESET low, all outputs SHALL be 0, synchronizers 0, D=0, counters 0 and FSMs IDLE, immediately and without waiting for CLK.
REQ-024 A RESET asserted mid-debounce or mid-repeat SHALL abort that activity, and no pulse SHALL emerge from pre-reset state.

Structure
REQ-025 Button index constants (U, L, C, R, D), the priority order and the default timing values SHALL live in the shared package chess_pkg.
REQ-026 A single sub-module, button_debounce, SHALL implement one channel (synchronizer, stability counter, D, repeat FSM), with a REPEAT_EN parameter.
REQ-027 The top level SHALL instantiate button_debounce five times and SHALL contain the priority arbiter and the output registers.

Verification (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; 20 ns clock)
REQ-028 BtnL_raw held 1 for 3 cycles, then 0 -> BtnL never pulses.
REQ-029 BtnC_raw held 1 for 40 cycles -> one BtnC pulse exactly 7 cycles after the first sampling edge, and no further pulses.
REQ-030 BtnU_raw held 1 for 40 cycles -> BtnU pulses at cycles 7, 17, 22, 27, 32 and 37, with none after the debounced release.
REQ-031 BtnC_raw and BtnR_raw rise on the same edge -> BtnC pulses at cycle 7, and BtnR stays 0 that cycle and on every later cycle.
REQ-032 RESET pulsed low at cycle 5 while BtnD_raw is held -> outputs drop to 0 asynchronously, and BtnD pulses exactly 7 cycles after RESET deasserts.
REQ-033 BtnR_raw toggles every 2 cycles for 30 cycles, then stays 1 -> exactly one BtnR pulse, 7 cycles after the final rise.
